// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus plus the IF/ID-facing fetch outputs.
interface mips_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_plus4;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output fetch_valid,
    output instr_out,
    output pc_plus4
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  fetch_valid,
    input  instr_out,
    input  pc_plus4
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS IF stage: PC owner, instruction-memory requester, NOP injection on redirect.
// Optional macro FETCH_SKID_BUF_EN: a stalled ack is kept in a one-entry buffer (HOLD) instead of re-fetched.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PC_Write,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  mips_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    FLUSH = 2'b10
  } fetch_state_t;

  fetch_state_t state_r;
  fetch_state_t state_s;
  logic [31:0]  pc_r;
  logic [31:0]  pc_s;
  logic [31:0]  buf_r;
  logic [31:0]  buf_s;
  logic         req_s;
  logic         valid_s;
  logic [31:0]  word_s;
  logic [31:0]  pc_inc_s;
  logic [31:0]  target_s;

  // Wraps modulo 2^32 by construction; low target bits are cleared by masking.
  assign pc_inc_s = pc_r + 32'd4;
  assign target_s = branch_target & 32'hFFFF_FFFC;

  // State, program counter and skid buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= FETCH;
      pc_r    <= RESET_PC;
      buf_r   <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      buf_r   <= buf_s;
    end
  end

  // Next-state and output decode; a redirect overrides whatever the current state would do.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    buf_s   = buf_r;
    valid_s = 1'b0;
    word_s  = 32'h0000_0000;
    req_s   = (state_r == FETCH);

    if (branch_taken) begin
      state_s = FLUSH;
      pc_s    = target_s;
      buf_s   = 32'h0000_0000;
    end else begin
      case (state_r)
        FETCH: begin
          if (bus.imem_ack) begin
            valid_s = 1'b1;
            word_s  = bus.imem_rdata;
            if (PC_Write) begin
              pc_s = pc_inc_s;
            end else begin
`ifdef FETCH_SKID_BUF_EN
              buf_s   = bus.imem_rdata;
              state_s = HOLD;
`else
              state_s = FETCH;
`endif
            end
          end else begin
            state_s = FETCH;
          end
        end
        HOLD: begin
          valid_s = 1'b1;
          word_s  = buf_r;
          if (PC_Write) begin
            pc_s    = pc_inc_s;
            buf_s   = 32'h0000_0000;
            state_s = FETCH;
          end else begin
            state_s = HOLD;
          end
        end
        FLUSH: begin
          state_s = FETCH;
        end
        default: begin
          state_s = FETCH;
          buf_s   = 32'h0000_0000;
        end
      endcase
    end
  end

  // Reset is folded in so the request and valid drop the instant reset asserts.
  assign bus.imem_req    = reset & req_s;
  assign bus.imem_addr   = pc_r;
  assign bus.fetch_valid = reset & valid_s;
  assign bus.instr_out   = (reset & valid_s) ? word_s : 32'h0000_0000;
  assign bus.pc_plus4    = pc_inc_s;

endmodule
